imem_boot: RTL and testbench
============================

IMEM_BOOT -- requirements
Module: imem_boot

Interface
REQ-001 Parameter DEPTH, 64, instruction memory depth in 32-bit words; SHALL be a power of two.
REQ-002 Parameter ADDR_W, 6, word-address width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_valid  input  1  one-cycle strobe marking rx_byte as valid (from UART receiver).
REQ-006 rx_byte  input  8  boot-stream byte.
REQ-007 pc_in  input  32  byte address from the PC register's pc_out.
REQ-008 instr  output  32  instruction at pc_in, to the decoder.
REQ-009 cpu_hold  output  1  high while loading; holds the PC and CPU state.
REQ-010 load_done  output  1  high once the program is fully loaded.
REQ-011 words_loaded  output  ADDR_W+1  count of words written in the current load.
REQ-012 misaligned  output  1  high when pc_in[1:0] != 0 in RUN.

Function
REQ-013 FSM states: HDR, DATA, RUN; reset state SHALL be HDR.
REQ-014 HDR: the first rx_valid byte SHALL set target word count N; N=0 or N>DEPTH SHALL be clamped to DEPTH; next state DATA.
REQ-015 DATA: bytes SHALL be assembled big-endian (first byte -> bits 31:24) using a 2-bit byte index.
REQ-016 On the 4th byte the assembled word SHALL be written to mem[words_loaded] in the same cycle, byte index cleared, words_loaded incremented.
REQ-017 When words_loaded reaches N after a write, the FSM SHALL enter RUN on the next edge; no further bytes are consumed.
REQ-018 rx_valid while in RUN SHALL be ignored; memory, counters and state unchanged.
REQ-019 cpu_hold SHALL be 1 in HDR and DATA, 0 in RUN; load_done SHALL be its inverse, both registered state decodes.
REQ-020 instr SHALL be 32'h00000000 (NOP) whenever cpu_hold=1.
REQ-021 In RUN, instr SHALL equal mem[pc_in[ADDR_W+1:2]] combinationally (zero-cycle read, single-cycle datapath).
REQ-022 Addresses beyond DEPTH SHALL wrap (upper pc_in bits ignored).
REQ-023 Misaligned pc_in SHALL still return the word at floor(pc_in/4) and assert misaligned.
REQ-024 Words not written in the current load SHALL retain prior contents (undefined after power-up).

Reset
REQ-025 Reset SHALL force state=HDR, byte index=0, words_loaded=0, N=0, cpu_hold=1, load_done=0, instr=0, misaligned=0.
REQ-026 Reset mid-load SHALL abandon a partial word; memory contents SHALL not be cleared.
REQ-027 Reset SHALL take effect immediately without a clock edge, release synchronously with clk.

Structure
REQ-028 FSM state encodings, DEPTH default and NOP constant SHALL live in the shared processor package.
REQ-029 The storage array SHALL be a separate sub-module imem_ram (one synchronous write port, one asynchronous read port).
REQ-030 The byte assembler and FSM SHALL reside in imem_boot; no other submodules.

Verification
REQ-031 Reset, then header 0x02, bytes 20 08 00 05 / 8C 09 00 04 -> words_loaded=2, cpu_hold falls; pc_in=0 -> instr=32'h20080005; pc_in=4 -> 32'h8C090004.
REQ-032 Header 0x00 then 256 bytes -> 64 words loaded, RUN entered; pc_in=32'h100 wraps to word 0.
REQ-033 Header 0x03, 6 bytes, assert reset -> state HDR, words_loaded=0, instr=0; previously written words preserved after a new 1-word load.
REQ-034 In RUN, drive rx_valid with 0xFF for 10 cycles -> memory, words_loaded, cpu_hold unchanged.
REQ-035 In RUN pc_in=32'h6 -> misaligned=1, instr=mem[1]; pc_in=32'h8 -> misaligned=0.
REQ-036 During loading with arbitrary pc_in -> instr=0 every cycle; PC bench held via cpu_hold.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared constants and FSM encoding for the boot-loaded instruction memory.
package imem_boot_pkg;
    localparam int          IMEM_DEPTH = 64;
    localparam logic [31:0] NOP        = 32'h0000_0000;
    typedef enum logic [1:0] {ST_HDR = 2'd0, ST_DATA = 2'd1, ST_RUN = 2'd2} boot_state_t;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: instruction storage with one synchronous write port and one asynchronous read port.
module imem_ram import imem_boot_pkg::*; #(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/imem_boot.sv
// imem_boot: loads a length-prefixed big-endian word stream into instruction memory,
// holding the CPU until the load completes, then serves zero-latency instruction fetches.
module imem_boot import imem_boot_pkg::*; #(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_valid,
    input  logic [7:0]      rx_byte,
    input  logic [31:0]     pc_in,
    output logic [31:0]     instr,
    output logic            cpu_hold,
    output logic            load_done,
    output logic [ADDR_W:0] words_loaded,
    output logic            misaligned
);
    boot_state_t     r_state, w_state_nx;
    logic [1:0]      r_idx;
    logic [23:0]     r_word;
    logic [ADDR_W:0] r_words, r_n, w_hdr_n, w_words_inc;
    logic [31:0]     w_rdata;
    logic            w_we, w_unused_pc;

    // A zero or oversized header means "fill the whole memory".
    assign w_hdr_n     = (rx_byte == 8'd0 || 32'(rx_byte) > DEPTH) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(rx_byte);
    assign w_words_inc = r_words + (ADDR_W+1)'(1);
    assign w_unused_pc = ^pc_in[31:ADDR_W+2];

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= ST_HDR;
        else       r_state <= w_state_nx;

    always_comb begin
        w_state_nx = r_state;
        w_we       = 1'b0;
        if (rx_valid && r_state == ST_HDR)
            w_state_nx = ST_DATA;
        else if (rx_valid && r_state == ST_DATA && r_idx == 2'd3) begin
            w_we = 1'b1;
            if (w_words_inc == r_n) w_state_nx = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_idx   <= '0;
            r_word  <= '0;
            r_words <= '0;
            r_n     <= '0;
        end else begin
            if (rx_valid && r_state == ST_HDR) begin
                r_n     <= w_hdr_n;
                r_words <= '0;
                r_idx   <= '0;
            end
            if (rx_valid && r_state == ST_DATA) begin
                r_idx  <= r_idx + 2'd1;
                r_word <= {r_word[15:0], rx_byte};
            end
            if (w_we) r_words <= w_words_inc;
        end

    imem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_words[ADDR_W-1:0]),
        .i_wdata ({r_word, rx_byte}),
        .i_raddr (pc_in[ADDR_W+1:2]),
        .o_rdata (w_rdata)
    );

    assign cpu_hold     = (r_state != ST_RUN);
    assign load_done    = ~cpu_hold;
    assign words_loaded = r_words;
    assign instr        = cpu_hold ? NOP : w_rdata;
    assign misaligned   = ~cpu_hold & (|pc_in[1:0]);
endmodule

// File: tb/tb_imem_boot.sv
// tb_imem_boot: randomized boot-stream loads checked against a word-array reference model.
module tb_imem_boot;
    localparam int D = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [31:0] pc_in = 32'h0;
    logic [31:0] instr;
    logic        cpu_hold, load_done, misaligned;
    logic [6:0]  words_loaded;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem_m [D];
    bit          known [D];
    logic [7:0]  bq [$];

    always #5 clk = ~clk;

    imem_boot #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .pc_in        (pc_in),
        .instr        (instr),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .words_loaded (words_loaded),
        .misaligned   (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        pc_in = $urandom;
        #1;
        chk("load_hold", 32'(cpu_hold), 32'd1);
        chk("load_nop", instr, 32'h0);
        chk("load_misaligned", 32'(misaligned), 32'd0);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic next_byte(output logic [7:0] b);
        if (bq.size() > 0) b = bq.pop_front();
        else               b = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] hdr);
        int n;
        int t;
        logic [31:0] word;
        logic [7:0]  b;
        n = (hdr == 8'd0 || int'(hdr) > D) ? D : int'(hdr);
        send(hdr);
        for (int w = 0; w < n; w++) begin
            word = 32'h0;
            for (int k = 0; k < 4; k++) begin
                next_byte(b);
                word = {word[23:0], b};
                send(b);
            end
            mem_m[w] = word;
            known[w] = 1'b1;
        end
        t = 0;
        while (cpu_hold !== 1'b0 && t < 8) begin
            @(negedge clk);
            t++;
        end
        chk("run_entered", 32'(cpu_hold), 32'd0);
        chk("load_done", 32'(load_done), 32'd1);
        chk("words_loaded", 32'(words_loaded), 32'(n));
    endtask

    task automatic check_mem(input string tag);
        logic [31:0] p;
        int idx;
        for (int i = 0; i < D; i++) begin
            p   = $urandom;
            idx = int'((p / 4) % D);
            @(negedge clk);
            pc_in = p;
            #1;
            if (known[idx]) chk(tag, instr, mem_m[idx]);
            chk("run_misaligned", 32'(misaligned), 32'((p % 4) != 0));
        end
    endtask

    task automatic ignore_rx(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_byte  = 8'hFF;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w0;
        logic [7:0]  b;
        int n_small;

        do_reset();

        bq = {8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        load(8'h02);
        @(negedge clk);
        pc_in = 32'h0; #1 chk("word0", instr, 32'h2008_0005);
        pc_in = 32'h4; #1 chk("word1", instr, 32'h8C09_0004);

        do_reset();
        load(8'h00);
        @(negedge clk);
        pc_in = 32'h100; #1 chk("wrap_100", instr, mem_m[0]);
        check_mem("full_read");

        ignore_rx(10);
        chk("ign_words", 32'(words_loaded), 32'd64);
        chk("ign_hold", 32'(cpu_hold), 32'd0);
        check_mem("ign_read");

        @(negedge clk);
        pc_in = 32'h6; #1;
        chk("mis_6", 32'(misaligned), 32'd1);
        chk("mis_6_instr", instr, mem_m[1]);
        pc_in = 32'h8; #1;
        chk("mis_8", 32'(misaligned), 32'd0);
        chk("mis_8_instr", instr, mem_m[2]);

        do_reset();
        send(8'h03);
        w0 = 32'h0;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            if (k < 4) w0 = {w0[23:0], b};
            send(b);
        end
        mem_m[0] = w0;
        do_reset();
        load(8'h01);
        check_mem("reload_read");

        do_reset();
        load(8'($urandom_range(65, 255)));
        check_mem("clamp_read");

        do_reset();
        n_small = $urandom_range(1, 63);
        load(8'(n_small));
        ignore_rx(10);
        chk("small_words", 32'(words_loaded), 32'(n_small));
        check_mem("small_read");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end
endmodule
